// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit for the MIPS fetch stage.
//
// Holds the architectural PC and picks the next PC every cycle from, highest
// priority first: exception vector, exception return (both only with the
// PC_EXC_EN macro defined), stall hold, jump target, branch target, and
// sequential increment.
//
// Optional feature macro: PC_EXC_EN
//   defined   : exc_req / eret are honoured and the EPC register exists.
//   undefined : exc_req / eret are ignored, epc is tied to zero.
//
// Parameters
//   WIDTH        PC / target width in bits (>= 8)
//   RESET_VECTOR PC value loaded by reset
//   EXC_VECTOR   PC value loaded on exception
//   STEP         sequential increment in bytes
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   stall          hold the current PC
//   branch_taken   load branch_target
//   branch_target  branch destination
//   jump           load jump_target
//   jump_target    jump destination
//   exc_req        take exception
//   eret           return from exception to epc
//   pc             current PC (registered)
//   pc4            pc + STEP, combinational, wraps modulo 2^WIDTH
//   redirect       registered, high the cycle after a non-sequential load
//   addr_err       registered, high the cycle after a misaligned target load
//   epc            saved exception PC (registered)
//
// Request semantics: all inputs are level requests sampled on the rising
// edge; there is no handshake. A jump or branch that coincides with stall is
// dropped, so the requester must hold it until stall is low.
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int               STEP         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             redirect,
  output logic             addr_err,
  output logic [WIDTH-1:0] epc
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Next-PC source selected this cycle.
  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_HOLD   = 3'd1,
    SRC_BRANCH = 3'd2,
    SRC_JUMP   = 3'd3,
    SRC_ERET   = 3'd4,
    SRC_EXC    = 3'd5
  } src_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic             addr_err_q, addr_err_d;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] pc_inc;
  src_e             src;
  logic             exc_take, eret_take;
  logic [WIDTH-1:0] tgt_raw;
  logic             tgt_checked;

  // Increment wraps naturally by truncation to WIDTH bits.
  assign pc_inc = pc_q + STEP_W;

`ifdef PC_EXC_EN
  assign exc_take  = exc_req;
  assign eret_take = eret;

  // EPC captures the PC of the cycle in which the exception is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q <= '0;
    end else if (exc_take) begin
      epc_q <= pc_q;
    end
  end
`else
  // Exception inputs stay on the interface but have no effect.
  logic unused_exc;
  assign unused_exc = exc_req ^ eret;
  assign exc_take   = 1'b0;
  assign eret_take  = 1'b0;
  assign epc_q      = '0;
`endif

  // Priority select. Exception and eret sit above stall, so they are taken
  // even while fetch is stalled.
  always_comb begin
    src = SRC_SEQ;
    if (exc_take) begin
      src = SRC_EXC;
    end else if (eret_take) begin
      src = SRC_ERET;
    end else if (stall) begin
      src = SRC_HOLD;
    end else if (jump) begin
      src = SRC_JUMP;
    end else if (branch_taken) begin
      src = SRC_BRANCH;
    end
  end

  // Target mux. Only jump/branch/eret targets go through the alignment
  // check; vectors and the sequential path are loaded as-is.
  always_comb begin
    tgt_raw     = pc_inc;
    tgt_checked = 1'b0;
    case (src)
      SRC_EXC:    tgt_raw = EXC_VECTOR;
      SRC_ERET:   begin tgt_raw = epc_q;         tgt_checked = 1'b1; end
      SRC_JUMP:   begin tgt_raw = jump_target;   tgt_checked = 1'b1; end
      SRC_BRANCH: begin tgt_raw = branch_target; tgt_checked = 1'b1; end
      SRC_HOLD:   tgt_raw = pc_q;
      default:    tgt_raw = pc_inc;
    endcase
  end

  always_comb begin
    pc_d       = tgt_raw;
    addr_err_d = 1'b0;
    if (tgt_checked) begin
      // Misaligned targets are forced to a word boundary and flagged.
      pc_d       = {tgt_raw[WIDTH-1:2], 2'b00};
      addr_err_d = |tgt_raw[1:0];
    end
    redirect_d = (src != SRC_SEQ) && (src != SRC_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc       = pc_q;
  assign pc4      = pc_inc;
  assign redirect = redirect_q;
  assign addr_err = addr_err_q;
  assign epc      = epc_q;

endmodule
